multicycle_controller: RTL
==========================

# multicycle_controller

Control FSM for the multicycle RV32I core: it sequences a shared-ALU, single-memory datapath through fetch, decode, execute, memory and writeback, one instruction at a time. It covers the instruction subset handled by `main_decoder`: lb/lh/lw/lbu/lhu, sb/sh/sw, R-type, I-type ALU, beq/bne/blt/bge, jal, jalr, lui and auipc. It adds wait states for a memory that signals completion with `mem_ready`. It sits beside the datapath and drives all of its register enables and mux selects.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  7  opcode field from the instruction register; valid from DECODE onward.
- `funct3`  in  3  funct3 field from the instruction register.
- `Zero`  in  1  ALU result equals zero.
- `ALUR31`  in  1  ALU result bit 31, the signed less-than flag.
- `mem_ready`  in  1  memory access completes this cycle.
- `PCWrite`  out  1  PC register enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `IRWrite`  out  1  instruction register and OldPC enable.
- `MemRead`, `MemWrite`  out  1 each  memory strobes.
- `RegWrite`  out  1  register file write enable.
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `ALUSrcB`  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ALUOp`  out  2  ALU operation class: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- `ImmSrc`  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `Store`  out  2  store width: 00 = byte, 01 = half, 10 = word.
- `Load`  out  3  load type: 000 = lb, 001 = lh, 010 = lw, 011 = lbu, 100 = lhu.
- `retire`  out  1  one-cycle pulse in the final state of each instruction.
- `illegal`  out  1  sticky flag: the controller has stopped on an illegal encoding.

## Operation
- The state register is 4 bits. Outputs are a Moore decode of the state, gated by `mem_ready`, `Zero` and `ALUR31` where listed. Any output not listed for a state is 0.
- `ImmSrc`, `Store` and `Load` are pure combinational functions of `op` and `funct3`. `Load` is 010 for non-loads; `Store` is 00 for non-stores.
- FETCH:
  - Drives AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite and PCWrite equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01, ALUOp=00, which precomputes the branch or jal target.
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111 or 0010111 → UPPER; any other → TRAP.
  - Also → TRAP on a load with funct3 ∉ {000,001,010,100,101}, a store with funct3 > 010, or a branch with funct3 ∉ {000,001,100,101}.
- MEMADR: drives ALUSrcA=10, ALUSrcB=01. Loads go to MEMREAD; stores go to MEMWRITE.
- MEMREAD:
  - Drives AdrSrc=1, MemRead=1.
  - Holds while `mem_ready`=0; goes to MEMWB when it is 1.
- MEMWB: drives ResultSrc=01, RegWrite=1, retire=1. Goes to FETCH.
- MEMWRITE:
  - Drives AdrSrc=1, MemWrite=1.
  - Holds while `mem_ready`=0. On `mem_ready`=1: retire=1, go to FETCH.
- EXECR: drives ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: drives ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- UPPER: drives ALUSrcB=01, ALUOp=00, and ALUSrcA = 11 for lui or 01 for auipc (selected by op[5]). Goes to ALUWB.
- ALUWB: drives ResultSrc=00, RegWrite=1, retire=1. Goes to FETCH.
- BRANCH:
  - Drives ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, retire=1.
  - PCWrite = take, where take is: funct3 000 → Zero; 001 → ~Zero; 100 → ALUR31; 101 → ~ALUR31.
  - Goes to FETCH.
- JALR: drives ALUSrcA=10, ALUSrcB=01, ALUOp=00, computing the target into ALUOut. Goes to JAL. Clearing target bit 0 is the datapath's job.
- JAL:
  - Drives ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - This loads the PC from ALUOut and computes OldPC+4 for the link register.
  - Goes to ALUWB.
- TRAP: `illegal`=1, all strobes 0. Stays in TRAP until reset.

## Timing
- Reset:
  - `reset` low forces state to FETCH and clears `illegal` immediately (asynchronous).
  - While `reset` is low, PCWrite, IRWrite, MemRead, MemWrite, RegWrite and retire are forced to 0. All selects are 0.
- Reset asserted mid-instruction abandons the instruction with no further writes. The first FETCH cycle starts on the first rising edge after release.
- Cycles per instruction with `mem_ready` held at 1:
  - branch: 3
  - R-type, I-type, sw/sh/sb, jal, lui/auipc: 4
  - loads and jalr: 5
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Strobes stay asserted throughout the wait.
- `retire` pulses exactly once per completed instruction and never in TRAP.
- `mem_ready` outside FETCH, MEMREAD and MEMWRITE is ignored.

## Test plan
- Reset: pulse reset low mid-MEMREAD → state is FETCH at once, all strobes 0, `illegal`=0. Release → MemRead=1 on the next cycle.
- lw (op 0000011, funct3 010), `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. Load=010; RegWrite only in cycle 5; retire in cycle 5.
- sw with `mem_ready` low for 2 cycles in MEMWRITE → MemWrite high for 3 cycles, Store=10, total 6 cycles, one retire.
- Branch funct3 001: Zero=0 → PCWrite=1 in BRANCH. Zero=1 → PCWrite=0. Funct3 101 with ALUR31=0 → PCWrite=1. Each takes 3 cycles.
- jalr → PCWrite=1 only in the JAL state (cycle 4) and in FETCH. RegWrite with ResultSrc=00 in cycle 5.
- op 1111111, or a load with funct3 011 → TRAP after DECODE. `illegal` stays 1 with no strobes for 10 cycles and is cleared only by reset.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero;
  logic       ALUR31;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [2:0] ImmSrc;
  logic [1:0] Store;
  logic [2:0] Load;
  logic       retire;
  logic       illegal;

  modport master (
    input  op, funct3, Zero, ALUR31, mem_ready,
    output PCWrite, AdrSrc, IRWrite, MemRead, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Store, Load,
           retire, illegal
  );

  modport slave (
    output op, funct3, Zero, ALUR31, mem_ready,
    input  PCWrite, AdrSrc, IRWrite, MemRead, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Store, Load,
           retire, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback with mem_ready wait states and a sticky trap.
module multicycle_controller (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master bus
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_UPPER    = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [3:0] state_q, state_d;

  function automatic logic branch_take(input logic [2:0] f3, input logic zero, input logic lt);
    case (f3)
      3'b000:  branch_take = zero;
      3'b001:  branch_take = ~zero;
      3'b100:  branch_take = lt;
      3'b101:  branch_take = ~lt;
      default: branch_take = 1'b0;
    endcase
  endfunction

  function automatic logic load_f3_ok(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_f3_ok = 1'b1;
      default:                                load_f3_ok = 1'b0;
    endcase
  endfunction

  function automatic logic branch_f3_ok(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b100, 3'b101: branch_f3_ok = 1'b1;
      default:                        branch_f3_ok = 1'b0;
    endcase
  endfunction

  // Next-state selection, including the illegal-encoding screen in DECODE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD:          state_d = load_f3_ok(bus.funct3) ? S_MEMADR : S_TRAP;
          OP_STORE:         state_d = (bus.funct3 <= 3'b010) ? S_MEMADR : S_TRAP;
          OP_RTYPE:         state_d = S_EXECR;
          OP_ITYPE:         state_d = S_EXECI;
          OP_BRANCH:        state_d = branch_f3_ok(bus.funct3) ? S_BRANCH : S_TRAP;
          OP_JAL:           state_d = S_JAL;
          OP_JALR:          state_d = S_JALR;
          OP_LUI, OP_AUIPC: state_d = S_UPPER;
          default:          state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_UPPER:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode; reset held low forces every strobe and select to 0.
  always_comb begin
    bus.PCWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ALUOp     = 2'b00;
    bus.retire    = 1'b0;
    bus.illegal   = 1'b0;
    if (!reset) begin
      bus.illegal = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          bus.MemRead   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          bus.IRWrite   = bus.mem_ready;
          bus.PCWrite   = bus.mem_ready;
        end
        S_DECODE: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b01;
        end
        S_MEMADR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
        end
        S_MEMREAD: begin
          bus.AdrSrc  = 1'b1;
          bus.MemRead = 1'b1;
        end
        S_MEMWB: begin
          bus.ResultSrc = 2'b01;
          bus.RegWrite  = 1'b1;
          bus.retire    = 1'b1;
        end
        S_MEMWRITE: begin
          bus.AdrSrc   = 1'b1;
          bus.MemWrite = 1'b1;
          bus.retire   = bus.mem_ready;
        end
        S_EXECR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUOp   = 2'b10;
        end
        S_EXECI: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
          bus.ALUOp   = 2'b10;
        end
        S_UPPER: begin
          bus.ALUSrcA = bus.op[5] ? 2'b11 : 2'b01;
          bus.ALUSrcB = 2'b01;
        end
        S_ALUWB: begin
          bus.RegWrite = 1'b1;
          bus.retire   = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUOp   = 2'b01;
          bus.retire  = 1'b1;
          bus.PCWrite = branch_take(bus.funct3, bus.Zero, bus.ALUR31);
        end
        S_JALR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
        end
        S_JAL: begin
          // PC takes the target already in ALUOut while the ALU forms OldPC+4.
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b10;
          bus.PCWrite = 1'b1;
        end
        S_TRAP:  bus.illegal = 1'b1;
        default: bus.illegal = 1'b1;
      endcase
    end
  end

  // Immediate format and memory access width follow the opcode and funct3 directly.
  always_comb begin
    bus.ImmSrc = 3'b000;
    bus.Store  = 2'b00;
    bus.Load   = 3'b010;
    case (bus.op)
      OP_STORE: begin
        bus.ImmSrc = 3'b001;
        case (bus.funct3)
          3'b001:  bus.Store = 2'b01;
          3'b010:  bus.Store = 2'b10;
          default: bus.Store = 2'b00;
        endcase
      end
      OP_LOAD: begin
        case (bus.funct3)
          3'b000:  bus.Load = 3'b000;
          3'b001:  bus.Load = 3'b001;
          3'b100:  bus.Load = 3'b011;
          3'b101:  bus.Load = 3'b100;
          default: bus.Load = 3'b010;
        endcase
      end
      OP_BRANCH:        bus.ImmSrc = 3'b010;
      OP_JAL:           bus.ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: bus.ImmSrc = 3'b100;
      default:          bus.ImmSrc = 3'b000;
    endcase
  end
endmodule
